// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: mode and state encodings shared by the universal shift register
package shift_reg_pkg;
    localparam logic [2:0] MODE_SHR = 3'd0;
    localparam logic [2:0] MODE_SHL = 3'd1;
    localparam logic [2:0] MODE_ASR = 3'd2;
    localparam logic [2:0] MODE_ROR = 3'd3;
    localparam logic [2:0] MODE_ROL = 3'd4;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;
    function automatic logic mode_valid(input logic [2:0] m);
        return m <= MODE_ROL;
    endfunction
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational single-position shift/rotate of a WIDTH-bit value
module shift_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic [2:0]       mode_i,
    input  logic             ser_in_i,
    output logic [WIDTH-1:0] val_o,
    output logic             bit_o
);
    logic left;
    logic fill;
    assign left  = (mode_i == MODE_SHL) || (mode_i == MODE_ROL);
    assign fill  = (mode_i == MODE_SHR) || (mode_i == MODE_SHL) ? ser_in_i :
                   (mode_i == MODE_ROR) ? val_i[0] : val_i[WIDTH-1];
    assign val_o = left ? {val_i[WIDTH-2:0], fill} : {fill, val_i[WIDTH-1:1]};
    assign bit_o = left ? val_i[WIDTH-1] : val_i[0];
endmodule

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: multi-mode shift register running N single-position steps per start
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_in_i,
    input  logic             start_i,
    input  logic [2:0]       mode_i,
    input  logic [CNT_W-1:0] amt_i,
    input  logic             ser_in_i,
    output logic [WIDTH-1:0] d_out_o,
    output logic             ser_out_o,
    output logic             busy_o,
    output logic             done_o
);
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] data_q, data_d, step_val;
    logic             ser_q, ser_d, done_q, done_d, step_bit;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .val_i   (data_q),
        .mode_i  (mode_q),
        .ser_in_i(ser_in_i),
        .val_o   (step_val),
        .bit_o   (step_bit)
    );

    // Busy shifting blocks load/start; load outranks start when idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        data_d  = data_q;
        ser_d   = ser_q;
        done_d  = 1'b0;
        if (state_q == ST_SHIFT) begin
            data_d = step_val;
            ser_d  = step_bit;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end else if (load_i) begin
            data_d = d_in_i;
            ser_d  = 1'b0;
        end else if (start_i && mode_valid(mode_i)) begin
            if (amt_i == '0) begin
                done_d = 1'b1;
            end else begin
                state_d = ST_SHIFT;
                mode_d  = mode_i;
                cnt_d   = amt_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_SHR;
            data_q  <= '0;
            ser_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
        end
    end

    assign d_out_o   = data_q;
    assign ser_out_o = ser_q;
    assign busy_o    = (state_q == ST_SHIFT);
    assign done_o    = done_q;
endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: scoreboard bench with an arithmetic reference model
module tb_shift_reg_univ;
    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       load_i = 1'b0;
    logic [7:0] d_in_i = '0;
    logic       start_i = 1'b0;
    logic [2:0] mode_i = '0;
    logic [3:0] amt_i = '0;
    logic       ser_in_i = 1'b0;
    logic [7:0] d_out_o;
    logic       ser_out_o, busy_o, done_o;

    typedef struct {
        logic [7:0] d;
        logic       s;
        int         n;
        int         k;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         run = 0;
    logic [7:0] m_data = '0;
    logic       m_ser = 1'b0;

    shift_reg_univ #(.WIDTH(8), .CNT_W(4)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .load_i   (load_i),
        .d_in_i   (d_in_i),
        .start_i  (start_i),
        .mode_i   (mode_i),
        .amt_i    (amt_i),
        .ser_in_i (ser_in_i),
        .d_out_o  (d_out_o),
        .ser_out_o(ser_out_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // n steps of mode m on x, with s[j-1] the serial bit at step j
    function automatic void model(input logic [7:0] x, input logic sp, input logic [2:0] m,
                                  input int n, input logic [15:0] s,
                                  output logic [7:0] r, output logic so);
        longint st;
        int xi, q;
        xi = int'(x);
        q = n % 8;
        r = x;
        so = sp;
        if (n == 0) return;
        case (m)
            3'd0: begin
                st = longint'(x);
                for (int j = 1; j <= n; j++) st |= longint'(s[j-1]) << (7 + j);
                r = 8'(st >> n);
                so = st[n-1];
            end
            3'd1: begin
                st = longint'(x) << n;
                for (int j = 1; j <= n; j++) st |= longint'(s[j-1]) << (n - j);
                r = 8'(st);
                so = st[8];
            end
            3'd2: begin
                xi = int'($signed(x));
                r = 8'(xi >>> n);
                so = xi[n-1];
            end
            3'd3: begin
                r = 8'((xi >> q) | (xi << (8 - q)));
                so = r[7];
            end
            default: begin
                r = 8'((xi << q) | (xi >> (8 - q)));
                so = r[0];
            end
        endcase
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst_i) begin
                run = 0;
            end else begin
                if (busy_o === 1'b1) run++;
                if (done_o === 1'b1) begin
                    chk("busy_in_done", int'(busy_o), 0);
                    if (sb.size() == 0) begin
                        chk("spurious_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("d_out", int'(d_out_o), int'(e.d));
                        chk("ser_out", int'(ser_out_o), int'(e.s));
                        chk("latency", cyc - e.k, e.n);
                        chk("busy_cycles", run, e.n);
                    end
                    run = 0;
                end
            end
        end
    end

    task automatic do_load(input logic [7:0] v, input logic with_start);
        @(negedge clk);
        load_i = 1'b1;
        d_in_i = v;
        start_i = with_start;
        mode_i = 3'd1;
        amt_i = 4'd2;
        @(negedge clk);
        load_i = 1'b0;
        start_i = 1'b0;
        m_data = v;
        m_ser = 1'b0;
        chk("load_data", int'(d_out_o), int'(v));
        chk("load_ser", int'(ser_out_o), 0);
        chk("load_busy", int'(busy_o), 0);
    endtask

    task automatic do_shift(input logic [2:0] m, input int n, input logic [15:0] s, input int inj);
        exp_t e;
        @(negedge clk);
        start_i = 1'b1;
        load_i = 1'b0;
        mode_i = m;
        amt_i = 4'(n);
        e.k = cyc + 1;
        e.n = n;
        model(m_data, m_ser, m, n, s, e.d, e.s);
        sb.push_back(e);
        m_data = e.d;
        m_ser = e.s;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            ser_in_i = s[j];
            if (int'($urandom_range(99)) < inj) begin
                load_i = 1'b1;
                start_i = 1'b1;
                d_in_i = 8'($urandom);
                mode_i = 3'($urandom_range(4));
                amt_i = 4'($urandom);
            end else begin
                load_i = 1'b0;
                start_i = 1'b0;
            end
        end
        @(negedge clk);
        start_i = 1'b0;
        load_i = 1'b0;
        chk("done_seen", int'(done_o), 1);
    endtask

    task automatic idle_quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            chk(name, int'(busy_o), 0);
            @(negedge clk);
        end
        chk({name, "_data"}, int'(d_out_o), int'(m_data));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_data", int'(d_out_o), 0);
        chk("rst_ser", int'(ser_out_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        rst_i = 1'b0;

        do_load(8'hFF, 1'b0);
        @(negedge clk);
        start_i = 1'b1;
        mode_i = 3'd0;
        amt_i = 4'd5;
        @(negedge clk);
        start_i = 1'b0;
        chk("mid_busy", int'(busy_o), 1);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        m_data = 8'h00;
        m_ser = 1'b0;
        chk("mid_rst_data", int'(d_out_o), 0);
        chk("mid_rst_busy", int'(busy_o), 0);
        chk("mid_rst_ser", int'(ser_out_o), 0);
        chk("mid_rst_done", int'(done_o), 0);
        idle_quiet("mid_rst_quiet", 8);

        do_load(8'hB4, 1'b0);
        do_shift(3'd0, 3, 16'h0000, 0);
        do_load(8'h80, 1'b0);
        do_shift(3'd2, 3, 16'($urandom), 0);
        do_load(8'h81, 1'b0);
        do_shift(3'd4, 9, 16'($urandom), 0);
        do_shift(3'd0, 0, 16'($urandom), 0);

        @(negedge clk);
        start_i = 1'b1;
        mode_i = 3'd6;
        amt_i = 4'd3;
        @(negedge clk);
        start_i = 1'b0;
        chk("rsv_done", int'(done_o), 0);
        idle_quiet("rsv_quiet", 4);

        do_load(8'hA5, 1'b0);
        do_shift(3'd3, 4, 16'($urandom), 100);
        do_load(8'h3C, 1'b1);
        chk("coll_done", int'(done_o), 0);
        idle_quiet("coll_quiet", 4);

        for (int i = 0; i < 80; i++) begin
            int r;
            r = int'($urandom_range(9));
            if (r < 2) do_load(8'($urandom), 1'($urandom));
            else if (r == 2) begin
                @(negedge clk);
                start_i = 1'b1;
                mode_i = 3'($urandom_range(7, 5));
                amt_i = 4'($urandom);
                @(negedge clk);
                start_i = 1'b0;
                chk("rnd_rsv_busy", int'(busy_o), 0);
            end else begin
                do_shift(3'($urandom_range(4)), int'($urandom_range(15)), 16'($urandom), 20);
            end
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
